// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and
// parity-mode constants common to the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    // 50 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous pad input; resets to the idle-high
// line level so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start-bit validation, mid-bit sampling, optional parity,
// stop/break handling and a single-entry valid/ready holding register.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = PAR_EVEN
) (
    input  logic                 system_clk,
    input  logic                 reset_n,
    input  logic                 uart0_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    // Counter restarts at 0 the cycle after each sample, so terminal counts are N-1
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic rxd_s;

    uart_rx_sync u_sync (
        .clk   (system_clk),
        .rst_n (reset_n),
        .d     (uart0_rxd),
        .q     (rxd_s)
    );

    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 sample;
    logic                 done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        done      = 1'b0;
        sample    = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                par_err_d = 1'b0;
                if (!rxd_s) state_d = START;
            end
            START: begin
                if (sample) begin
                    cnt_d   = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    cnt_d     = '0;
                    par_err_d = (^shift_q) ^ rxd_s ^ PARITY_ODD;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    cnt_d   = '0;
                    done    = 1'b1;
                    // A low stop bit may be a break; wait for the line to recover
                    state_d = rxd_s ? IDLE : BRK_WAIT;
                end
            end
            BRK_WAIT: begin
                cnt_d = '0;
                if (rxd_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q && !rx_ready;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        if (done) begin
            // Load if empty or the held word is leaving this cycle
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                rx_valid_d   = 1'b1;
                frame_err_d  = !rxd_s;
                parity_err_d = PARITY_EN ? par_err_q : 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule
